prm_edge_query_seq: RTL and testbench

PRM_EDGE_QUERY_SEQ -- requirements
Module: prm_edge_query_seq

---
 rtl/prm_chk_pkg.sv | 21 ++
 rtl/prm_tag_pipe.sv | 54 +++++
 rtl/prm_edge_query_seq.sv | 153 +++++++++++++++
 tb/tb_prm_edge_query_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/prm_chk_pkg.sv
// Shared types and widths for the edge-query sequencer and its tag pipeline.
// Codes are 15 bits wide, one per checker input; step indices are 8 bits.
package prm_chk_pkg;

  localparam int CODE_W = 15;
  localparam int IDX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } state_e;

  // Travels alongside each query; the step index is meaningful only while valid is set.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/prm_tag_pipe.sv
// DEPTH-stage delay line of {valid, step index} tags that lines each query up with its checker result.
// With DEPTH = 0 the tag passes straight through, so the result is expected in the same cycle as the query.
module prm_tag_pipe
  import prm_chk_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t out_tag,
  output logic busy
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_tag = in_tag;
      assign busy    = 1'b0;
    end else begin : g_pipe
      tag_t stage_q [DEPTH];
      tag_t stage_d [DEPTH];

      always_comb begin
        stage_d[0] = in_tag;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // NOTE: state is updated with non-blocking assignments so every stage samples its neighbour's pre-edge value.
      always_ff @(posedge clk) begin
        if (rst) begin
          // NOTE: only the valid bits are reset; a stale idx behind a cleared valid bit is never consumed.
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i].valid <= 1'b0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      // NOTE: give every combinational output a default before the loop, so no path leaves it unassigned and no latch is inferred.
      always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          busy = busy | stage_q[i].valid;
        end
      end

      assign out_tag = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/prm_edge_query_seq.sv
// Walks a stride sequence of configuration codes through an external edge-mask checker.
// Scanning stops at the first blocked code, and the scan reports whether a code was blocked and the index of that first code.
module prm_edge_query_seq
  import prm_chk_pkg::*;
#(
  parameter int CHK_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_base,
  input  logic [CODE_W-1:0] req_stride,
  input  logic [IDX_W-1:0]  req_count,
  output logic              q_valid,
  output logic [CODE_W-1:0] q_code,
  input  logic              chk_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] stride_q, stride_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  step_q, step_d;
  logic              q_valid_q, q_valid_d;
  logic [CODE_W-1:0] q_code_q, q_code_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;

  tag_t issue_tag;
  tag_t chk_tag;
  logic pipe_busy;
  logic hit_now;
  logic last_step;

  assign issue_tag = '{valid: q_valid_q, idx: step_q};

  prm_tag_pipe #(
    .DEPTH (CHK_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (issue_tag),
    .out_tag (chk_tag),
    .busy    (pipe_busy)
  );

  // Only the first blocked result counts; chk_mask is ignored whenever no tag is aligned with it.
  assign hit_now   = chk_tag.valid & chk_mask & ~rsp_hit_q;
  assign last_step = (step_q == count_q - IDX_W'(1));

  always_comb begin
    state_d   = state_q;
    stride_d  = stride_q;
    count_d   = count_q;
    step_d    = step_q;
    q_valid_d = q_valid_q;
    q_code_d  = q_code_q;
    rsp_hit_d = rsp_hit_q;
    rsp_idx_d = rsp_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          stride_d  = req_stride;
          count_d   = req_count;
          step_d    = '0;
          rsp_hit_d = 1'b0;
          rsp_idx_d = '0;
          if (req_count == '0) begin
            state_d = ST_RESP;
          end else begin
            state_d   = ST_ISSUE;
            q_valid_d = 1'b1;
            q_code_d  = req_base;
          end
        end
      end

      ST_ISSUE: begin
        if (hit_now) begin
          rsp_hit_d = 1'b1;
          rsp_idx_d = chk_tag.idx;
          q_valid_d = 1'b0;
          q_code_d  = '0;
          state_d   = ST_DRAIN;
        end else if (last_step) begin
          q_valid_d = 1'b0;
          q_code_d  = '0;
          state_d   = ST_DRAIN;
        end else begin
          // Running adder; the sum wraps modulo 2^CODE_W by truncation.
          step_d   = step_q + IDX_W'(1);
          q_code_d = q_code_q + stride_q;
        end
      end

      ST_DRAIN: begin
        // pipe_busy includes the output stage, so the last result is still sampled here before moving on.
        if (pipe_busy) begin
          if (hit_now) begin
            rsp_hit_d = 1'b1;
            rsp_idx_d = chk_tag.idx;
          end
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stride_q  <= '0;
      count_q   <= '0;
      step_q    <= '0;
      q_valid_q <= 1'b0;
      q_code_q  <= '0;
      rsp_hit_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      stride_q  <= stride_d;
      count_q   <= count_d;
      step_q    <= step_d;
      q_valid_q <= q_valid_d;
      q_code_q  <= q_code_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  // Outputs are gated by rst so they read as idle for the whole reset window, including the partial cycle before the first reset edge.
  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign q_valid   = q_valid_q & ~rst;
  assign q_code    = rst ? '0 : q_code_q;
  assign rsp_valid = (state_q == ST_RESP) & ~rst;
  assign rsp_hit   = rsp_hit_q & ~rst;
  assign rsp_idx   = rst ? '0 : rsp_idx_q;

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Directed bench for prm_edge_query_seq: expected codes and responses are queued when a request is driven.
// Each queued value is checked when the DUT produces the matching output.
module tb_prm_edge_query_seq;
  import prm_chk_pkg::*;

  localparam int LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_base;
  logic [CODE_W-1:0] req_stride;
  logic [IDX_W-1:0]  req_count;
  logic              q_valid;
  logic [CODE_W-1:0] q_code;
  logic              chk_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;

  always #5 clk = ~clk;

  prm_edge_query_seq #(
    .CHK_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_count  (req_count),
    .q_valid    (q_valid),
    .q_code     (q_code),
    .chk_mask   (chk_mask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_idx    (rsp_idx)
  );

  int tests = 0;
  int fails = 0;

  logic [CODE_W-1:0] exp_codes [$];
  logic [IDX_W:0]    exp_rsp   [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic check_query(input string tag);
    if (q_valid === 1'b1) begin
      if (exp_codes.size() == 0) check({tag, "_unexpected_q"}, 32'(q_valid), 32'd0);
      else check({tag, "_q_code"}, 32'(q_code), 32'(exp_codes.pop_front()));
    end else begin
      check({tag, "_idle_q_code"}, 32'(q_code), 32'd0);
    end
  endtask

  // abort_at >= 0 asserts rst in that cycle of the scan instead of waiting for a response.
  task automatic scan(input string tag, input logic [CODE_W-1:0] base, input logic [CODE_W-1:0] stride,
                      input logic [IDX_W-1:0] cnt, input logic [15:0] hits, input int hold, input int abort_at);
    int k0 = -1;
    int n_issue;
    int exp_lat;
    int j;
    bit got = 1'b0;
    logic [IDX_W:0] r;

    for (int i = 0; i < int'(cnt) && i < 16; i++) if (hits[i] && k0 < 0) k0 = i;
    n_issue = (k0 < 0) ? int'(cnt) : ((k0 + LAT + 1 < int'(cnt)) ? k0 + LAT + 1 : int'(cnt));
    exp_lat = (cnt == 0) ? 0 : n_issue + LAT + 1;
    for (int i = 0; i < n_issue; i++) exp_codes.push_back(CODE_W'(int'(base) + i * int'(stride)));
    r = (k0 >= 0) ? {1'b1, IDX_W'(k0)} : '0;
    exp_rsp.push_back(r);

    rsp_ready = (hold == 0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_base = base; req_stride = stride; req_count = cnt;
    next_cycle();
    req_valid = 1'b0; req_base = '0; req_stride = '0; req_count = '0;

    for (j = 0; j < 300; j++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      check({tag, "_busy_req_ready"}, 32'(req_ready), 32'd0);
      check_query(tag);
      if (j == abort_at) begin
        rst = 1'b1;
        chk_mask = 1'b1;
        #1;
        check({tag, "_rst_q_valid"}, 32'(q_valid), 32'd0);
        check({tag, "_rst_q_code"}, 32'(q_code), 32'd0);
        check({tag, "_rst_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        exp_codes.delete();
        exp_rsp.delete();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check({tag, "_post_rst_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_post_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        next_cycle();
        check({tag, "_stale_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_stale_q_valid"}, 32'(q_valid), 32'd0);
        chk_mask = 1'b0;
        rsp_ready = 1'b1;
        return;
      end
      chk_mask = (j >= LAT && j - LAT < int'(cnt) && j - LAT < 16) ? hits[j-LAT] : 1'b0;
      next_cycle();
    end
    chk_mask = 1'b0;

    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    check({tag, "_rsp_latency"}, 32'(j), 32'(exp_lat));
    r = exp_rsp.pop_front();
    check({tag, "_rsp_hit"}, 32'(rsp_hit), 32'(r[IDX_W]));
    check({tag, "_rsp_idx"}, 32'(rsp_idx), 32'(r[IDX_W-1:0]));
    check({tag, "_all_issued"}, 32'(exp_codes.size()), 32'd0);
    exp_codes.delete();

    for (int h = 0; h < hold; h++) begin
      next_cycle();
      check({tag, "_hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rsp_hit"}, 32'(rsp_hit), 32'(r[IDX_W]));
      check({tag, "_hold_rsp_idx"}, 32'(rsp_idx), 32'(r[IDX_W-1:0]));
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    next_cycle();
    check({tag, "_done_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_base = '0; req_stride = '0; req_count = '0;
    chk_mask = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_q_valid", 32'(q_valid), 32'd0);
    check("reset_q_code", 32'(q_code), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    check("reset_rsp_idx", 32'(rsp_idx), 32'd0);
    rst = 1'b0;
    #1;
    check("first_cycle_req_ready", 32'(req_ready), 32'd1);
    next_cycle();

    scan("inc4",  15'h0010, 15'h0001, 8'd4,  16'h0000, 0, -1);
    scan("wrap3", 15'h7FFE, 15'h0003, 8'd3,  16'h0000, 0, -1);
    scan("hit2",  15'h0100, 15'h0011, 8'd10, 16'h0024, 0, -1);
    scan("cnt0",  15'h1234, 15'h0001, 8'd0,  16'hFFFF, 0, -1);
    scan("hold5", 15'h0AAA, 15'h0100, 8'd3,  16'h0002, 5, -1);
    scan("last",  15'h7FF0, 15'h0008, 8'd5,  16'h0010, 0, -1);
    scan("abort", 15'h0200, 15'h0002, 8'd8,  16'h0000, 0, 3);
    scan("post",  15'h0300, 15'h0001, 8'd5,  16'h0000, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
